// File: rtl/clk25m_ctrl.sv
// Power/clock sequencer between the DCM and the ASIC chain: waits for a stable
// lock, gates the 25 MHz chip clocks on, then releases chip reset (reverse on teardown).
module clk25m_ctrl #(
  parameter int LOCK_WAIT = 1024,
  parameter int RST_DLY   = 256,
  parameter int OFF_DLY   = 64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       locked,
  input  logic       en_req,
  input  logic       lost_clr,
  output logic       clk25m_on,
  output logic       asic_rstn,
  output logic       ready,
  output logic       lock_lost,
  output logic [2:0] state
);

  localparam int MAX_AB  = (LOCK_WAIT > RST_DLY) ? LOCK_WAIT : RST_DLY;
  localparam int MAX_DLY = (MAX_AB > OFF_DLY) ? MAX_AB : OFF_DLY;
  localparam int CW      = $clog2(MAX_DLY) + 1;

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_WAIT - 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_DLY - 1);
  localparam logic [CW-1:0] OFF_LAST  = CW'(OFF_DLY - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_CLK_ON    = 3'd2,
    S_RUN       = 3'd3,
    S_STOP      = 3'd4
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          locked_m;
  logic          locked_s;
  logic          clk_on_d;
  logic          run_d;
  logic          fault_d;
  logic          fault_q;

  // Two-flop synchronizer: locked comes straight from the DCM, unrelated to clk.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= locked;
      locked_s <= locked_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Lock loss while the chips are clocked beats every other transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (en_req) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (!en_req) begin
          state_d = S_IDLE;
        end else if (locked_s) begin
          if (cnt_q == LOCK_LAST) state_d = S_CLK_ON;
          else                    cnt_d   = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
        end
      end
      S_CLK_ON: begin
        if (!locked_s)             state_d = S_IDLE;
        else if (!en_req)          state_d = S_STOP;
        else if (cnt_q == RST_LAST) state_d = S_RUN;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      S_RUN: begin
        if (!locked_s)    state_d = S_IDLE;
        else if (!en_req) state_d = S_STOP;
      end
      S_STOP: begin
        if (!locked_s)              state_d = S_IDLE;
        else if (cnt_q == OFF_LAST) state_d = S_IDLE;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    clk_on_d = (state_q == S_CLK_ON) || (state_q == S_RUN) || (state_q == S_STOP);
    run_d    = (state_q == S_RUN);
    fault_d  = clk_on_d && !locked_s;
  end

  // The fault is staged one flop so lock_lost moves on the same edge as the gates drop.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      clk25m_on <= 1'b0;
      asic_rstn <= 1'b0;
      ready     <= 1'b0;
      fault_q   <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      clk25m_on <= clk_on_d;
      asic_rstn <= run_d;
      ready     <= run_d;
      fault_q   <= fault_d;
      if (fault_q)       lock_lost <= 1'b1;
      else if (lost_clr) lock_lost <= 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_clk25m_ctrl.sv
// Bench for clk25m_ctrl: directed sequences plus random traffic, checked every
// cycle against a phase/streak reference model through an expected-output queue.
module tb_clk25m_ctrl;

  localparam int LW = 16;
  localparam int RD = 8;
  localparam int OD = 4;

  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_CLKON = 2;
  localparam int P_RUN   = 3;
  localparam int P_STOP  = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       locked = 1'b0;
  logic       en_req = 1'b0;
  logic       lost_clr = 1'b0;
  logic       clk25m_on;
  logic       asic_rstn;
  logic       ready;
  logic       lock_lost;
  logic [2:0] state;

  always #5 clk = ~clk;

  clk25m_ctrl #(.LOCK_WAIT(LW), .RST_DLY(RD), .OFF_DLY(OD)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .locked    (locked),
    .en_req    (en_req),
    .lost_clr  (lost_clr),
    .clk25m_on (clk25m_on),
    .asic_rstn (asic_rstn),
    .ready     (ready),
    .lock_lost (lock_lost),
    .state     (state)
  );

  int checks = 0;
  int errors = 0;
  int sb_cycle = 0;
  logic [6:0] exp_q[$];
  logic [6:0] sb_exp;
  logic [6:0] sb_got;

  // reference model: phase, streak of qualifying edges in the phase, lock history
  int m_phase = P_IDLE;
  int m_run = 0;
  bit m_s1, m_s2, m_on, m_rn, m_rdy, m_lost, m_evt;

  logic [2:0] o_state = '0;
  logic o_on = 1'b0, o_rn = 1'b0, o_rdy = 1'b0, o_lost = 1'b0;

  function automatic void model_step(input bit r, input bit l, input bit e, input bit c);
    bit ls;
    bit active;
    int nxt;
    if (!r) begin
      m_phase = P_IDLE; m_run = 0; m_s1 = 0; m_s2 = 0;
      m_on = 0; m_rn = 0; m_rdy = 0; m_lost = 0; m_evt = 0;
      return;
    end
    ls     = m_s2;
    active = (m_phase == P_CLKON) || (m_phase == P_RUN) || (m_phase == P_STOP);
    m_lost = m_evt || (m_lost && !c);
    m_evt  = active && !ls;
    m_on   = active;
    m_rn   = (m_phase == P_RUN);
    m_rdy  = m_rn;
    nxt = m_phase;
    if (active && !ls) begin
      nxt = P_IDLE;
    end else begin
      case (m_phase)
        P_IDLE: if (e) nxt = P_WAIT;
        P_WAIT: begin
          if (!e) nxt = P_IDLE;
          else if (ls) begin
            m_run++;
            if (m_run == LW) nxt = P_CLKON;
          end else m_run = 0;
        end
        P_CLKON: begin
          if (!e) nxt = P_STOP;
          else begin
            m_run++;
            if (m_run == RD) nxt = P_RUN;
          end
        end
        P_RUN: if (!e) nxt = P_STOP;
        P_STOP: begin
          m_run++;
          if (m_run == OD) nxt = P_IDLE;
        end
        default: nxt = P_IDLE;
      endcase
    end
    if (nxt != m_phase) m_run = 0;
    m_phase = nxt;
    m_s2 = m_s1;
    m_s1 = l;
  endfunction

  // one clock edge: drive, predict, then observe after the edge
  task automatic step(input bit r, input bit l, input bit e, input bit c);
    @(negedge clk);
    rstn = r; locked = l; en_req = e; lost_clr = c;
    model_step(r, l, e, c);
    exp_q.push_back({3'(m_phase), m_on, m_rn, m_rdy, m_lost});
    @(posedge clk);
    #2;
    o_state = state; o_on = clk25m_on; o_rn = asic_rstn; o_rdy = ready; o_lost = lock_lost;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  task automatic run_until(input string name, input int tgt, input int max_steps);
    bit found;
    found = 0;
    for (int i = 0; i < max_steps && !found; i++) begin
      step(1, 1, 1, 0);
      if (o_state == 3'(tgt)) found = 1;
    end
    check(name, int'(found), 1);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      sb_got = {state, clk25m_on, asic_rstn, ready, lock_lost};
      checks++;
      if (sb_got !== sb_exp) begin
        errors++;
        $display("FAIL sb cyc %0d got st=%0d on=%b rstn=%b rdy=%b lost=%b exp st=%0d on=%b rstn=%b rdy=%b lost=%b",
                 sb_cycle, sb_got[6:4], sb_got[3], sb_got[2], sb_got[1], sb_got[0],
                 sb_exp[6:4], sb_exp[3], sb_exp[2], sb_exp[1], sb_exp[0]);
      end
      checks++;
      if (asic_rstn === 1'b1 && clk25m_on !== 1'b1) begin
        errors++;
        $display("FAIL rstn_without_clk cyc %0d got asic_rstn=%b clk25m_on=%b", sb_cycle, asic_rstn, clk25m_on);
      end
      sb_cycle++;
    end
  end

  initial begin
    int on_at, rn_at, rn_fall, on_fall, wait_at, lost_at, any_rn, any_lost;
    bit r_lk, r_en, r_rst, r_clr;

    repeat (3) step(0, 1, 0, 0);
    check("reset_state", int'(o_state), 0);
    check("reset_clk_on", int'(o_on), 0);
    check("reset_asic_rstn", int'(o_rn), 0);
    check("reset_ready", int'(o_rdy), 0);
    check("reset_lock_lost", int'(o_lost), 0);

    // bring-up with lock already stable
    repeat (9) step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    check("bu_wait_state", int'(o_state), P_WAIT);
    on_at = -1; rn_at = -1;
    for (int i = 1; i <= 60; i++) begin
      step(1, 1, 1, 0);
      if (o_on && on_at < 0) on_at = i;
      if (o_rn && rn_at < 0) rn_at = i;
    end
    check("bu_clk_on_rise", on_at, LW + 1);
    check("bu_rstn_rise", rn_at, LW + 1 + RD);
    check("bu_run_state", int'(o_state), P_RUN);
    check("bu_ready", int'(o_rdy), 1);

    // orderly shutdown, en_req re-raised during STOP
    rn_fall = -1; on_fall = -1; wait_at = -1;
    step(1, 1, 0, 0);
    check("sd_stop_state", int'(o_state), P_STOP);
    for (int i = 1; i <= OD + 3; i++) begin
      step(1, 1, (i >= 2), 0);
      if (!o_rn && rn_fall < 0) rn_fall = i;
      if (!o_on && on_fall < 0) on_fall = i;
      if (o_state == 3'(P_WAIT) && wait_at < 0) wait_at = i;
    end
    check("sd_rstn_fall", rn_fall, 1);
    check("sd_clk_off", on_fall, OD + 1);
    check("sd_restart_wait", wait_at, OD + 1);

    // lock loss in RUN, then clear
    run_until("reach_run_1", P_RUN, 80);
    on_fall = -1; lost_at = -1;
    for (int i = 0; i <= 5; i++) begin
      step(1, 0, 1, 0);
      if (!o_on && on_fall < 0) on_fall = i;
      if (o_lost && lost_at < 0) lost_at = i;
    end
    check("ll_clk_off", on_fall, 3);
    check("ll_lost_rise", lost_at, 3);
    check("ll_rstn_low", int'(o_rn), 0);
    step(1, 1, 1, 0);
    check("ll_lost_sticky", int'(o_lost), 1);
    step(1, 1, 1, 1);
    check("ll_lost_clear", int'(o_lost), 0);

    // fresh loss coinciding with lost_clr: set wins
    run_until("reach_run_2", P_RUN, 80);
    for (int i = 0; i <= 5; i++) begin
      step(1, 0, 1, (i == 3));
      if (i == 3) check("sw_lost_at_clr", int'(o_lost), 1);
    end
    check("sw_lost_hold", int'(o_lost), 1);
    step(1, 1, 1, 1);

    // abort in CLK_ON at cnt=3
    run_until("reach_clk_on", P_CLKON, 80);
    repeat (3) step(1, 1, 1, 0);
    any_rn = 0; on_fall = -1;
    step(1, 1, 0, 0);
    check("ab_stop_state", int'(o_state), P_STOP);
    if (o_rn) any_rn = 1;
    for (int i = 1; i <= OD + 3; i++) begin
      step(1, 1, 0, 0);
      if (o_rn) any_rn = 1;
      if (!o_on && on_fall < 0) on_fall = i;
    end
    check("ab_rstn_never", any_rn, 0);
    check("ab_clk_off", on_fall, OD + 1);

    // lock glitch in WAIT_LOCK at cnt=10
    step(1, 1, 1, 0);
    repeat (10) step(1, 1, 1, 0);
    on_at = -1; any_lost = 0;
    for (int i = 0; i <= 40; i++) begin
      step(1, (i >= 3), 1, 0);
      if (o_on && on_at < 0) on_at = i;
      if (o_lost) any_lost = 1;
    end
    check("gl_clk_on_delay", on_at, LW + 5);
    check("gl_no_fault", any_lost, 0);

    // synchronous reset mid-RUN, then full bring-up again
    check("rs_in_run", int'(o_state), P_RUN);
    step(0, 1, 1, 0);
    check("rs_state", int'(o_state), 0);
    check("rs_outputs", int'({o_on, o_rn, o_rdy, o_lost}), 0);
    on_at = -1; rn_at = -1;
    for (int i = 1; i <= 40; i++) begin
      step(1, 1, 1, 0);
      if (o_on && on_at < 0) on_at = i;
      if (o_rn && rn_at < 0) rn_at = i;
    end
    check("rs_clk_on_rise", on_at, LW + 3);
    check("rs_rstn_rise", rn_at, LW + 3 + RD);

    // random traffic
    r_lk = 1; r_en = 1;
    for (int i = 0; i < 4000; i++) begin
      if (r_lk) begin
        if ($urandom_range(0, 59) == 0) r_lk = 0;
      end else if ($urandom_range(0, 3) == 0) r_lk = 1;
      if ($urandom_range(0, 79) == 0) r_en = ~r_en;
      r_clr = ($urandom_range(0, 19) == 0);
      r_rst = ($urandom_range(0, 499) != 0);
      step(r_rst, r_lk, r_en, r_clr);
    end

    repeat (3) @(posedge clk);
    #2;
    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
